// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 bus bundle shared by a burst master and its slave.
// Clock and reset travel inside the bundle so both sides see the same timing.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;

    modport master (
        input  clk, rst, ack, err, dat_sm,
        output cyc, stb, we, sel, adr, cti, bte, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, cti, bte, dat_ms,
        output ack, err, dat_sm
    );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone incrementing-burst reader that streams a circular memory region
// into a small FIFO for a valid/ready consumer. A burst is launched only when
// the FIFO already has room for all of its beats, so pushes never overflow.
module wb_burst_reader #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int unsigned NWORDS     = 2048
) (
    wshb_if.master      wb_m,
    input  logic        enable,
    input  logic        restart,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready
);

    localparam int unsigned PW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BW = $clog2(BURST_LEN);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   word_ptr_q, word_ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            pend_q, pend_d;

    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;

    logic            cyc;
    logic            last_beat;
    logic            space_ok;
    logic            push;
    logic            pop;
    logic [PW-1:0]   word_ptr_inc;

    assign cyc       = (state_q == StBurst);
    assign last_beat = (beat_q == BW'(BURST_LEN - 1));
    assign space_ok  = (LW'(FIFO_DEPTH) - level_q) >= LW'(BURST_LEN);
    assign pop       = pix_valid && pix_ready;

    // The region length need not be a power of two, so wrap explicitly.
    assign word_ptr_inc = (word_ptr_q == PW'(NWORDS - 1)) ? '0 : word_ptr_q + 1'b1;

    // Bus outputs: read-only, full-word, linear bursts.
    assign wb_m.cyc    = cyc;
    assign wb_m.stb    = cyc;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.bte    = 2'b00;
    assign wb_m.dat_ms = 32'h0;
    assign wb_m.cti    = !cyc ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
    assign wb_m.adr    = BASE_ADR + (32'(word_ptr_q) << 2);

    // Next-state: burst launch, beat accounting, pointer advance and restart handling.
    always_comb begin
        state_d    = state_q;
        word_ptr_d = word_ptr_q;
        beat_d     = beat_q;
        pend_d     = pend_q;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A restart is applied here, whether fresh or deferred from a burst.
                if (restart || pend_q) begin
                    word_ptr_d = '0;
                    pend_d     = 1'b0;
                end
                if (enable && space_ok) begin
                    state_d = StBurst;
                    beat_d  = '0;
                end
            end
            StBurst: begin
                if (restart) begin
                    pend_d = 1'b1;
                end
                if (wb_m.err) begin
                    // Abort without consuming the beat; the same address is retried later.
                    state_d = StIdle;
                    beat_d  = '0;
                end else if (wb_m.ack) begin
                    push       = 1'b1;
                    word_ptr_d = word_ptr_inc;
                    beat_d     = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = StIdle;
                        beat_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            state_q    <= StIdle;
            word_ptr_q <= '0;
            beat_q     <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_ptr_q <= word_ptr_d;
            beat_q     <= beat_d;
            pend_q     <= pend_d;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset since validity is tracked by level.
    always_ff @(posedge wb_m.clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wb_m.dat_sm;
        end
    end

    // Head word comes straight from flop storage, so back-to-back pops have no bubble.
    assign pix_data  = mem_q[rd_ptr_q];
    assign pix_valid = (level_q != '0);

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: a Wishbone slave model with optional
// error injection, a scoreboard of expected words and directed scenario tasks.
module tb_wb_burst_reader;

    localparam int unsigned BL   = 16;
    localparam int unsigned FD   = 32;
    localparam int unsigned NW   = 64;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        pix_ready = 1'b0;
    logic [31:0] pix_data;
    logic        pix_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wshb_if wb (.clk(clk), .rst(rst));

    wb_burst_reader #(
        .BURST_LEN (BL),
        .FIFO_DEPTH(FD),
        .BASE_ADR  (BASE),
        .NWORDS    (NW)
    ) dut (
        .wb_m     (wb),
        .enable   (enable),
        .restart  (restart),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready)
    );

    // Memory image: distinct word for every index of the region.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return 32'hA500_0000 ^ (w * 32'h0001_0003);
    endfunction

    assign wb.dat_sm = mem_word(wb.adr);

    // Slave: acks the cycle after stb, then every cycle until the end-of-burst ack.
    int err_beat = -1;
    int sbeat;
    always @(posedge clk) begin
        if (rst) begin
            wb.ack <= 1'b0;
            wb.err <= 1'b0;
            sbeat  <= 0;
        end else begin
            wb.ack <= 1'b0;
            wb.err <= 1'b0;
            if (!wb.cyc) sbeat <= 0;
            else if (wb.ack) sbeat <= sbeat + 1;
            if (wb.cyc && wb.stb && !wb.err && !(wb.ack && wb.cti == 3'b111)) begin
                if (err_beat >= 0 && (sbeat + (wb.ack ? 1 : 0)) == err_beat) wb.err <= 1'b1;
                else wb.ack <= 1'b1;
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    logic [31:0] q[$];
    int          model_ptr = 0;
    bit          model_pend = 0;
    bit          prev_cyc = 0;
    int          mon_beat = 0;
    int          launches = 0;
    int          pops = 0;
    logic [31:0] last_launch = '0;
    logic [2:0]  exp_cti;
    logic [31:0] exp_word;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            model_ptr  = 0;
            model_pend = 0;
            prev_cyc   = 0;
            mon_beat   = 0;
        end else begin
            checks++;
            if (pix_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL pix_valid: got %b expected %b", pix_valid, q.size() != 0);
            end
            if (wb.cyc && !prev_cyc) begin
                launches++;
                last_launch = wb.adr;
                mon_beat    = 0;
            end
            if (wb.cyc) begin
                checks++;
                if (wb.stb !== 1'b1 || wb.we !== 1'b0 || wb.sel !== 4'hF || wb.bte !== 2'b00) begin
                    errors++;
                    $display("FAIL bus_ctrl: got stb=%b we=%b sel=%h bte=%b expected 1 0 f 00",
                             wb.stb, wb.we, wb.sel, wb.bte);
                end
            end
            if (wb.cyc && wb.err === 1'b1) begin
                // errored beat: nothing pushed, pointer stays
            end else if (wb.cyc && wb.ack === 1'b1) begin
                checks++;
                if (wb.adr !== BASE + 32'(4 * model_ptr)) begin
                    errors++;
                    $display("FAIL beat_adr: got %h expected %h", wb.adr, BASE + 32'(4 * model_ptr));
                end
                exp_cti = (mon_beat == BL - 1) ? 3'b111 : 3'b010;
                checks++;
                if (mon_beat >= BL || wb.cti !== exp_cti) begin
                    errors++;
                    $display("FAIL beat_cti: got %b at beat %0d expected %b", wb.cti, mon_beat, exp_cti);
                end
                q.push_back(mem_word(BASE + 32'(4 * model_ptr)));
                model_ptr = (model_ptr + 1) % NW;
                mon_beat++;
            end
            if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
                checks++;
                pops++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected no data available", pix_data);
                end else begin
                    exp_word = q.pop_front();
                    if (pix_data !== exp_word) begin
                        errors++;
                        $display("FAIL pop_data: got %h expected %h", pix_data, exp_word);
                    end
                end
            end
            if (restart === 1'b1) begin
                if (wb.cyc) model_pend = 1;
                else model_ptr = 0;
            end
            if (!wb.cyc && model_pend) begin
                model_ptr  = 0;
                model_pend = 0;
            end
            prev_cyc = wb.cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_launch(input string name, output logic [31:0] adr);
        int n0;
        bit ok;
        n0 = launches;
        ok = 0;
        adr = 'x;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (launches > n0) begin
                ok = 1;
                adr = last_launch;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: got no burst launch expected one within 400 cycles", name);
        end
        #1;
    endtask

    task automatic wait_cyc_low(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (wb.cyc === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: got cyc stuck high expected cyc=0 within 400 cycles", name);
        end
    endtask

    task automatic drain_all(input string name);
        bit ok;
        ok = 0;
        pix_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (pix_valid === 1'b0) begin
                ok = 1;
                break;
            end
        end
        pix_ready = 1'b0;
        checks++;
        if (!ok || q.size() != 0) begin
            errors++;
            $display("FAIL %s: got pix_valid=%b with %0d expected words left expected empty",
                     name, pix_valid, q.size());
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic check_adr(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        checks++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || wb.cti !== 3'b000 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got cyc=%b stb=%b cti=%b valid=%b expected 0 0 000 0",
                     wb.cyc, wb.stb, wb.cti, pix_valid);
        end
        checks++;
        if (wb.we !== 1'b0 || wb.sel !== 4'hF || wb.bte !== 2'b00 || wb.dat_ms !== 32'h0) begin
            errors++;
            $display("FAIL reset_static: got we=%b sel=%h bte=%b dat_ms=%h expected 0 f 00 0",
                     wb.we, wb.sel, wb.bte, wb.dat_ms);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (wb.cyc !== 1'b0) begin
            errors++;
            $display("FAIL idle_disabled: got cyc=%b expected 0", wb.cyc);
        end
    endtask

    task automatic test_fill();
        logic [31:0] a;
        int n0;
        pix_ready = 1'b0;
        enable = 1'b1;
        n0 = launches;
        wait_launch("fill_first", a);
        check_adr("fill_first_adr", a, BASE);
        wait_launch("fill_second", a);
        check_adr("fill_second_adr", a, BASE + 32'h40);
        wait_cyc_low("fill_end");
        repeat (30) tick();
        checks++;
        if (launches - n0 != 2 || wb.cyc !== 1'b0 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got %0d bursts cyc=%b valid=%b expected 2 bursts cyc=0 valid=1",
                     launches - n0, wb.cyc, pix_valid);
        end
    endtask

    task automatic test_drain();
        logic [31:0] a;
        int p0;
        p0 = pops;
        pix_ready = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        pix_ready = 1'b0;
        checks++;
        if (pops - p0 != 16) begin
            errors++;
            $display("FAIL drain_count: got %0d pops expected 16", pops - p0);
        end
        wait_launch("drain_launch", a);
        check_adr("drain_launch_adr", a, BASE + 32'h80);
        wait_cyc_low("drain_end");
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit found;
        found = 0;
        pix_ready = 1'b1;
        for (int i = 0; i < 8 && !found; i++) begin
            wait_launch("wrap_seek", a);
            if (a === BASE + 32'hC0) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_seek: got last launch %h expected %h", a, BASE + 32'hC0);
        end
        wait_launch("wrap_next", a);
        check_adr("wrap_next_adr", a, BASE);
        repeat (40) tick();
        enable = 1'b0;
        wait_cyc_low("wrap_end");
        drain_all("wrap_drain");
    endtask

    task automatic test_restart();
        logic [31:0] a;
        bit found;
        bit hit;
        pulse_reset();
        pix_ready = 1'b1;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            wait_launch("rst_seek", a);
            if (a === BASE + 32'h40) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL restart_seek: got launch %h expected %h", a, BASE + 32'h40);
        end
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (wb.cyc === 1'b1 && wb.ack === 1'b1 && mon_beat == 5) begin
                hit = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL restart_beat5: got no beat 5 expected one within 40 cycles");
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wait_launch("restart_next", a);
        check_adr("restart_next_adr", a, BASE);
        enable = 1'b0;
        wait_cyc_low("restart_end");
        repeat (3) tick();
        // idle restart applies immediately
        restart = 1'b1;
        tick();
        restart = 1'b0;
        enable = 1'b1;
        wait_launch("restart_idle", a);
        check_adr("restart_idle_adr", a, BASE);
        enable = 1'b0;
        wait_cyc_low("restart_idle_end");
        drain_all("restart_drain");
    endtask

    task automatic test_err();
        logic [31:0] a;
        bit hit;
        int p0;
        pulse_reset();
        p0 = pops;
        err_beat = 3;
        pix_ready = 1'b0;
        enable = 1'b1;
        wait_launch("err_first", a);
        check_adr("err_first_adr", a, BASE);
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wb.err === 1'b1) begin
                hit = 1;
                break;
            end
        end
        err_beat = -1;
        checks++;
        if (!hit || mon_beat != 3) begin
            errors++;
            $display("FAIL err_words: got %0d words before err expected 3", mon_beat);
        end
        tick();
        checks++;
        if (wb.cyc !== 1'b0) begin
            errors++;
            $display("FAIL err_cyc_drop: got cyc=%b expected 0", wb.cyc);
        end
        wait_launch("err_retry", a);
        check_adr("err_retry_adr", a, BASE + 32'hC);
        wait_cyc_low("err_retry_end");
        enable = 1'b0;
        repeat (3) tick();
        drain_all("err_drain");
        checks++;
        if (pops - p0 != 19) begin
            errors++;
            $display("FAIL err_total: got %0d words expected 19", pops - p0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        bit hit;
        pix_ready = 1'b0;
        enable = 1'b1;
        wait_launch("rmid_launch", a);
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (wb.cyc === 1'b1 && wb.ack === 1'b1 && mon_beat == 7) begin
                hit = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rmid_beat7: got no beat 7 expected one within 40 cycles");
        end
        rst = 1'b1;
        tick();
        checks++;
        if (wb.cyc !== 1'b0 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: got cyc=%b valid=%b expected 0 0", wb.cyc, pix_valid);
        end
        rst = 1'b0;
        wait_launch("rmid_after", a);
        check_adr("rmid_after_adr", a, BASE);
        enable = 1'b0;
        wait_cyc_low("rmid_end");
        drain_all("rmid_drain");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_restart();
        test_err();
        test_reset_mid();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_burst_reader.md
WB_BURST_READER -- requirements
Module: wb_burst_reader

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning Wishbone beats per burst, power of 2 and at least 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, meaning words of internal read FIFO, power of 2 and at least BURST_LEN.
REQ-003 SHALL have parameter BASE_ADR, default 32'h0, meaning byte address of region start, word aligned.
REQ-004 SHALL have parameter NWORDS, default 2048, meaning region length in 32-bit words, a multiple of BURST_LEN.
REQ-005 SHALL have port wb_m.clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port wb_m.rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port wb_m, wshb_if.master, bundle: Wishbone master driving cyc, stb, we, sel, adr, cti, bte, dat_ms and sampling ack, err, dat_sm.
REQ-008 SHALL have port enable, input, 1 bit: when 1, bursts may be launched.
REQ-009 SHALL have port restart, input, 1 bit: one-cycle pulse that returns the read pointer to BASE_ADR.
REQ-010 SHALL have port pix_data, output, 32 bits: FIFO head word.
REQ-011 SHALL have port pix_valid, output, 1 bit: FIFO not empty.
REQ-012 SHALL have port pix_ready, input, 1 bit: consumer accepts pix_data when pix_valid and pix_ready are both 1.

Function
REQ-013 SHALL implement FSM states IDLE and BURST.
REQ-014 SHALL go from IDLE to BURST when enable=1 and free FIFO space (FIFO_DEPTH - level) >= BURST_LEN.
REQ-015 SHALL assert cyc=1 and stb=1 from the first BURST cycle, and hold them continuously until the ack of the last beat.
REQ-016 SHALL drive we=0, sel=4'hF, bte=2'b00 and dat_ms=0 at all times.
REQ-017 SHALL drive cti=3'b010 for beats 0 to BURST_LEN-2 and cti=3'b111 for beat BURST_LEN-1.
REQ-018 SHALL set adr = BASE_ADR + 4*word_ptr, where word_ptr advances by 1 on each ack.
REQ-019 SHALL wrap word_ptr from NWORDS-1 to 0; a burst never straddles the wrap because NWORDS is a multiple of BURST_LEN.
REQ-020 SHALL push dat_sm into the FIFO in the same cycle as each ack with cyc=1; acks while cyc=0 SHALL be ignored.
REQ-021 SHALL, after the ack with cti=3'b111, drop cyc and stb in the next cycle and return to IDLE.
REQ-022 SHALL have at least one IDLE cycle between bursts.
REQ-023 SHALL never overflow the FIFO: space is reserved at launch per REQ-014, so a push into a full FIFO cannot occur.
REQ-024 SHALL, on a simultaneous push and pop, leave level unchanged, with both operations taking effect.
REQ-025 SHALL keep pix_valid = (level != 0), and SHALL present pix_data as registered FIFO read data with no bubble between consecutive pops.
REQ-026 SHALL, if enable falls during BURST, complete the current burst, then stay in IDLE.
REQ-027 SHALL apply a restart seen in IDLE at once, setting word_ptr=0.
REQ-028 SHALL hold a restart seen in BURST pending and apply it on return to IDLE; restart SHALL NOT flush the FIFO.
REQ-029 SHALL, on err=1 during BURST, discard the beat (no push, no pointer advance), drop cyc/stb next cycle, return to IDLE, and retry the same address at the next launch.

Reset
REQ-030 SHALL, on wb_m.rst=1 at a clock edge, set state=IDLE, cyc=0, stb=0, cti=3'b000, word_ptr=0, FIFO level=0, pix_valid=0 and restart-pending=0.
REQ-031 SHALL apply REQ-030 identically if reset arrives mid-burst: cyc drops in the cycle after reset is sampled, and FIFO contents are discarded.
REQ-032 SHALL leave pix_data undefined while pix_valid=0.

Verification
REQ-033 Reset then enable=1, pix_ready=0, slave acking one cycle after stb -> burst at adr BASE_ADR..BASE_ADR+0x3C, cti 010x15 then 111, then one more burst; level=32, no third burst.
REQ-034 FIFO holds 32 words, pix_ready=1 for 16 cycles -> 16 words out in order, then a new burst launches at adr BASE_ADR+0x80.
REQ-035 NWORDS=32, continuous drain -> after adr BASE_ADR+0x7C the next burst starts at BASE_ADR; data sequence equals memory contents in order.
REQ-036 restart pulsed on beat 5 of a burst at word 16 -> burst completes through word 31, next burst starts at word 0.
REQ-037 err=1 on beat 3 of the first burst -> exactly 3 words pushed, cyc=0 next cycle, next burst begins at BASE_ADR+0xC.
REQ-038 rst=1 on beat 7 -> cyc=0 and pix_valid=0 one cycle later; after release, first adr=BASE_ADR.
